// File: rtl/fetch_decode_skid_stage.sv
// Fetch->decode pipeline register with a 2-entry skid buffer,
// synchronous flush and a saturating decode-stall counter.
module fetch_decode_skid_stage #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = '0,
  parameter int                    STALL_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [ADDR_WIDTH-1:0]  fetch_pc_address,
  input  logic [DATA_WIDTH-1:0]  fetch_instruction,
  output logic                   decode_valid,
  input  logic                   decode_ready,
  output logic [ADDR_WIDTH-1:0]  decode_pc_address,
  output logic [DATA_WIDTH-1:0]  decode_instruction,
  output logic [STALL_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                 state;
  logic                   ready_q;
  logic                   valid_q;
  logic [ADDR_WIDTH-1:0]  main_pc;
  logic [DATA_WIDTH-1:0]  main_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;
  logic [DATA_WIDTH-1:0]  skid_instr;
  logic [STALL_WIDTH-1:0] stall_q;

  logic in_fire;
  logic out_fire;
  logic stall;
  logic stall_sat;

  assign in_fire   = fetch_valid && ready_q;
  assign out_fire  = valid_q && decode_ready;
  assign stall     = valid_q && !decode_ready;
  assign stall_sat = &stall_q;

  assign fetch_ready        = ready_q;
  assign decode_valid       = valid_q;
  assign decode_pc_address  = main_pc;
  assign decode_instruction = main_instr;
  assign stall_count        = stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
      stall_q    <= '0;
    end else begin
      if (stall && !stall_sat)
        stall_q <= stall_q + STALL_WIDTH'(1);

      // flush wins over every transition and drops in_fire
      if (flush) begin
        state      <= EMPTY;
        ready_q    <= 1'b1;
        valid_q    <= 1'b0;
        main_pc    <= '0;
        main_instr <= NOP_INSTR;
        skid_pc    <= '0;
        skid_instr <= NOP_INSTR;
      end else begin
        unique case (state)
          EMPTY: begin
            if (in_fire) begin
              main_pc    <= fetch_pc_address;
              main_instr <= fetch_instruction;
              valid_q    <= 1'b1;
              state      <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_pc    <= fetch_pc_address;
              main_instr <= fetch_instruction;
            end else if (in_fire) begin
              skid_pc    <= fetch_pc_address;
              skid_instr <= fetch_instruction;
              ready_q    <= 1'b0;
              state      <= TWO;
            end else if (out_fire) begin
              main_pc    <= '0;
              main_instr <= NOP_INSTR;
              valid_q    <= 1'b0;
              state      <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_pc    <= skid_pc;
              main_instr <= skid_instr;
              skid_pc    <= '0;
              skid_instr <= NOP_INSTR;
              ready_q    <= 1'b1;
              state      <= ONE;
            end
          end
          default: begin
            state      <= EMPTY;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_skid_stage.sv
// Self-checking bench: directed vector table, FIFO scoreboard,
// stall saturation on a narrow counter, async reset mid-transfer.
module tb_fetch_decode_skid_stage;

  localparam int             AW  = 12;
  localparam int             DW  = 32;
  localparam int             SW  = 16;
  localparam logic [DW-1:0]  NOP = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [AW-1:0] fetch_pc;
  logic [DW-1:0] fetch_instr;
  logic          decode_valid;
  logic          decode_ready;
  logic [AW-1:0] decode_pc;
  logic [DW-1:0] decode_instr;
  logic [SW-1:0] stall_count;

  logic          s_rst_n;
  logic          s_fv;
  logic          s_fr;
  logic          s_dv;
  logic          s_dr;
  logic [AW-1:0] s_dpc;
  logic [DW-1:0] s_dinstr;
  logic [1:0]    s_stall;

  fetch_decode_skid_stage #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NOP_INSTR(NOP), .STALL_WIDTH(SW)
  ) dut (
    .clock(clk), .reset(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc_address(fetch_pc),
    .fetch_instruction(fetch_instr),
    .decode_valid(decode_valid), .decode_ready(decode_ready),
    .decode_pc_address(decode_pc),
    .decode_instruction(decode_instr),
    .stall_count(stall_count)
  );

  fetch_decode_skid_stage #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NOP_INSTR(NOP), .STALL_WIDTH(2)
  ) dut_sat (
    .clock(clk), .reset(s_rst_n), .flush(1'b0),
    .fetch_valid(s_fv), .fetch_ready(s_fr),
    .fetch_pc_address(12'h0AA),
    .fetch_instruction(32'h1234_5678),
    .decode_valid(s_dv), .decode_ready(s_dr),
    .decode_pc_address(s_dpc),
    .decode_instruction(s_dinstr),
    .stall_count(s_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int total  = 0;
  int passed = 0;
  logic [AW+DW-1:0] q[$];
  int unsigned exp_stall;

  typedef struct {
    logic          fv;
    logic [AW-1:0] pc;
    logic          dr;
    logic          fl;
    logic          e_dv;
    logic [AW-1:0] e_pc;
    logic          e_fr;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t v(logic fv, logic [AW-1:0] pc, logic dr,
                             logic fl, logic e_dv,
                             logic [AW-1:0] e_pc, logic e_fr);
    vec_t r;
    r.fv = fv; r.pc = pc; r.dr = dr; r.fl = fl;
    r.e_dv = e_dv; r.e_pc = e_pc; r.e_fr = e_fr;
    return r;
  endfunction

  function automatic logic [DW-1:0] mk(logic [AW-1:0] pc);
    return {20'hC0DE5, pc};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic check_state();
    logic [AW+DW-1:0] head;
    chk("fetch_ready", 64'(fetch_ready), 64'(q.size() < 2));
    chk("decode_valid", 64'(decode_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      head = q[0];
      chk("sb_pc", 64'(decode_pc), 64'(head[AW+DW-1:DW]));
      chk("sb_instr", 64'(decode_instr), 64'(head[DW-1:0]));
    end else begin
      chk("idle_pc", 64'(decode_pc), 64'h0);
      chk("idle_instr", 64'(decode_instr), 64'(NOP));
    end
    chk("stall_count", 64'(stall_count), 64'(exp_stall));
  endtask

  // model step: update scoreboard from pre-edge inputs, clock, compare
  task automatic tick();
    logic m_fr;
    logic m_dv;
    m_fr = q.size() < 2;
    m_dv = q.size() > 0;
    if (m_dv && decode_ready) void'(q.pop_front());
    if (m_dv && !decode_ready && exp_stall != 32'h0000_FFFF)
      exp_stall++;
    if (flush) q.delete();
    else if (fetch_valid && m_fr) q.push_back({fetch_pc, fetch_instr});
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    tbl[0]  = v(1, 12'h004, 1, 0, 1, 12'h004, 1);
    tbl[1]  = v(1, 12'h008, 1, 0, 1, 12'h008, 1);
    tbl[2]  = v(1, 12'h00C, 1, 0, 1, 12'h00C, 1);
    tbl[3]  = v(0, 12'h000, 1, 0, 0, 12'h000, 1);
    tbl[4]  = v(1, 12'h010, 0, 0, 1, 12'h010, 1);
    tbl[5]  = v(1, 12'h014, 0, 0, 1, 12'h010, 0);
    tbl[6]  = v(1, 12'h018, 0, 0, 1, 12'h010, 0);
    tbl[7]  = v(0, 12'h000, 1, 0, 1, 12'h014, 1);
    tbl[8]  = v(0, 12'h000, 1, 0, 0, 12'h000, 1);
    tbl[9]  = v(1, 12'h030, 0, 0, 1, 12'h030, 1);
    tbl[10] = v(1, 12'h034, 0, 0, 1, 12'h030, 0);
    tbl[11] = v(1, 12'h020, 0, 1, 0, 12'h000, 1);
    tbl[12] = v(0, 12'h000, 1, 0, 0, 12'h000, 1);

    rst_n = 1'b0; s_rst_n = 1'b0;
    flush = 1'b0; fetch_valid = 1'b0; decode_ready = 1'b0;
    fetch_pc = '0; fetch_instr = '0;
    s_fv = 1'b0; s_dr = 1'b0;
    exp_stall = 0;
    #12;
    chk("rst_fetch_ready", 64'(fetch_ready), 64'h1);
    chk("rst_decode_valid", 64'(decode_valid), 64'h0);
    chk("rst_pc", 64'(decode_pc), 64'h0);
    chk("rst_instr", 64'(decode_instr), 64'(NOP));
    chk("rst_stall", 64'(stall_count), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; s_rst_n = 1'b1;

    // directed vectors: streaming, skid fill/drain, flush from TWO
    for (int i = 0; i < 13; i++) begin
      fetch_valid  = tbl[i].fv;
      fetch_pc     = tbl[i].pc;
      fetch_instr  = mk(tbl[i].pc);
      decode_ready = tbl[i].dr;
      flush        = tbl[i].fl;
      tick();
      chk($sformatf("vec%0d_dv", i), 64'(decode_valid), 64'(tbl[i].e_dv));
      chk($sformatf("vec%0d_pc", i), 64'(decode_pc), 64'(tbl[i].e_pc));
      chk($sformatf("vec%0d_instr", i), 64'(decode_instr),
          64'(tbl[i].e_dv ? mk(tbl[i].e_pc) : NOP));
      chk($sformatf("vec%0d_fr", i), 64'(fetch_ready), 64'(tbl[i].e_fr));
    end
    flush = 1'b0;

    // five stall cycles
    begin
      int unsigned s0;
      fetch_valid = 1'b1; fetch_pc = 12'h040;
      fetch_instr = mk(12'h040); decode_ready = 1'b0;
      tick();
      fetch_valid = 1'b0;
      s0 = exp_stall;
      repeat (5) tick();
      chk("stall_plus5", 64'(stall_count), 64'(s0 + 5));
      decode_ready = 1'b1;
      tick();
    end

    // narrow counter saturates at 3
    fetch_valid = 1'b0; decode_ready = 1'b1;
    s_fv = 1'b1; s_dr = 1'b0;
    @(posedge clk); #1;
    s_fv = 1'b0;
    chk("sat_valid", 64'(s_dv), 64'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_two", 64'(s_stall), 64'h2);
    repeat (4) @(posedge clk);
    #1;
    chk("sat_three", 64'(s_stall), 64'h3);
    tick();

    // async reset while two entries held
    decode_ready = 1'b0; fetch_valid = 1'b1;
    fetch_pc = 12'h050; fetch_instr = mk(12'h050);
    tick();
    fetch_pc = 12'h054; fetch_instr = mk(12'h054);
    tick();
    chk("two_fr", 64'(fetch_ready), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dv", 64'(decode_valid), 64'h0);
    chk("arst_fr", 64'(fetch_ready), 64'h1);
    chk("arst_pc", 64'(decode_pc), 64'h0);
    chk("arst_instr", 64'(decode_instr), 64'(NOP));
    chk("arst_stall", 64'(stall_count), 64'h0);
    q.delete();
    exp_stall = 0;
    fetch_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      fetch_valid  = ($urandom_range(0, 3) != 0);
      fetch_pc     = AW'($urandom);
      fetch_instr  = $urandom;
      decode_ready = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 63) == 0);
      if ((i % 16) == 0) begin
        decode_ready = ~decode_ready;
        #1;
        chk("fr_no_comb", 64'(fetch_ready), 64'(q.size() < 2));
      end
      tick();
    end
    flush = 1'b0; fetch_valid = 1'b0; decode_ready = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
